// File: rtl/multicycle_control_unit_if.sv
// multicycle_control_unit_if: IR fields, flags and datapath controls between
// the multi-cycle control FSM (master) and the RV32 datapath (slave).
// Ports: OP/Funct3/Funct7/Zero/MemReady into the FSM; selects, enables,
//        ULAControl, ImmSrc, Illegal and debug State out of the FSM.
interface multicycle_control_unit_if #(
    parameter int ULA_W = 3
);
    logic [6:0]       OP;
    logic [2:0]       Funct3;
    logic [6:0]       Funct7;
    logic             Zero;
    logic             MemReady;
    logic             PCWrite;
    logic             AdrSrc;
    logic             MemWrite;
    logic             IRWrite;
    logic [1:0]       ResultSrc;
    logic [1:0]       ULASrcA;
    logic [1:0]       ULASrcB;
    logic [ULA_W-1:0] ULAControl;
    logic [2:0]       ImmSrc;
    logic             RegWrite;
    logic             Illegal;
    logic [3:0]       State;

    modport master (
        input  OP, Funct3, Funct7, Zero, MemReady,
        output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc,
        output ULASrcA, ULASrcB, ULAControl, ImmSrc,
        output RegWrite, Illegal, State
    );

    modport slave (
        output OP, Funct3, Funct7, Zero, MemReady,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc,
        input  ULASrcA, ULASrcB, ULAControl, ImmSrc,
        input  RegWrite, Illegal, State
    );
endinterface

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: Moore control FSM sequencing RV32 instructions
// through fetch/decode/execute/memory/writeback with a MemReady wait.
// Ports: CLK, RSTn (synchronous, active low), bus (master modport) carrying
//        IR fields and flags in, datapath controls, Illegal and State out.
module multicycle_control_unit #(
    parameter int ULA_W      = 3,
    parameter bit ENABLE_BNE = 1'b1,
    parameter bit ENABLE_JAL = 1'b1
) (
    input  logic                     CLK,
    input  logic                     RSTn,
    multicycle_control_unit_if.master bus
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        ALUWB    = 4'd7,
        EXECI    = 4'd8,
        JAL      = 4'd9,
        BRANCH   = 4'd10,
        LUI      = 4'd11,
        TRAP     = 4'd12
    } state_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;
    localparam logic [2:0] ALU_SLL = 3'b110;
    localparam logic [2:0] ALU_SRL = 3'b111;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_U = 3'b011;
    localparam logic [2:0] IMM_J = 3'b100;

    state_t state;
    state_t nxt;
    state_t dec_nxt;

    logic       is_load, is_store, is_r, is_i;
    logic       is_lui, is_br, is_jal;
    logic       f7_zero, f7_sub, is_shift;
    logic       mem_ok, r_ok, i_ok, br_ok;
    logic [2:0] f3_alu, r_alu;

    logic       pc_write, adr_src, mem_write, ir_write;
    logic       reg_write, illegal;
    logic [1:0] result_src, src_a, src_b;
    logic [2:0] alu, imm_src;
    logic [ULA_W-1:0] ula_ext;

    assign is_load  = bus.OP == OP_LOAD;
    assign is_store = bus.OP == OP_STORE;
    assign is_r     = bus.OP == OP_R;
    assign is_i     = bus.OP == OP_I;
    assign is_lui   = bus.OP == OP_LUI;
    assign is_br    = bus.OP == OP_BR;
    assign is_jal   = bus.OP == OP_JAL;

    assign f7_zero  = bus.Funct7 == 7'b0000000;
    assign f7_sub   = bus.Funct7 == 7'b0100000;
    assign is_shift = bus.Funct3 == 3'b001 || bus.Funct3 == 3'b101;

    assign mem_ok = bus.Funct3 == 3'b010;
    // Only SUB may carry a non-zero funct7; funct3 011 has no ALU code.
    assign r_ok   = (f7_zero && bus.Funct3 != 3'b011)
                 || (f7_sub && bus.Funct3 == 3'b000);
    assign i_ok   = bus.Funct3 != 3'b011 && (!is_shift || f7_zero);
    assign br_ok  = bus.Funct3 == 3'b000
                 || (ENABLE_BNE && bus.Funct3 == 3'b001);

    always_comb begin
        f3_alu = ALU_ADD;
        case (bus.Funct3)
            3'b001:  f3_alu = ALU_SLL;
            3'b010:  f3_alu = ALU_SLT;
            3'b100:  f3_alu = ALU_XOR;
            3'b101:  f3_alu = ALU_SRL;
            3'b110:  f3_alu = ALU_OR;
            3'b111:  f3_alu = ALU_AND;
            default: f3_alu = ALU_ADD;
        endcase
    end

    assign r_alu = (f7_sub && bus.Funct3 == 3'b000) ? ALU_SUB : f3_alu;

    always_comb begin
        dec_nxt = TRAP;
        unique case (1'b1)
            is_load && mem_ok:    dec_nxt = MEMADR;
            is_store && mem_ok:   dec_nxt = MEMADR;
            is_r && r_ok:         dec_nxt = EXECR;
            is_i && i_ok:         dec_nxt = EXECI;
            is_lui:               dec_nxt = LUI;
            is_br && br_ok:       dec_nxt = BRANCH;
            is_jal && ENABLE_JAL: dec_nxt = JAL;
            default:              dec_nxt = TRAP;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RSTn) state <= FETCH;
        else       state <= nxt;
    end

    always_comb begin
        nxt        = state;
        pc_write   = 1'b0;
        adr_src    = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        illegal    = 1'b0;
        result_src = 2'b00;
        src_a      = 2'b00;
        src_b      = 2'b00;
        alu        = ALU_ADD;
        imm_src    = IMM_I;
        case (state)
            FETCH: begin
                src_b      = 2'b10;
                result_src = 2'b10;
                ir_write   = bus.MemReady;
                pc_write   = bus.MemReady;
                if (bus.MemReady) nxt = DECODE;
            end
            DECODE: begin
                // OldPC + imm lands in ALUOut for BRANCH/JAL.
                src_a   = 2'b01;
                src_b   = 2'b01;
                imm_src = is_jal ? IMM_J : IMM_B;
                nxt     = dec_nxt;
            end
            MEMADR: begin
                src_a   = 2'b10;
                src_b   = 2'b01;
                imm_src = is_store ? IMM_S : IMM_I;
                nxt     = is_store ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                adr_src = 1'b1;
                if (bus.MemReady) nxt = MEMWB;
            end
            MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                nxt        = FETCH;
            end
            MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
                if (bus.MemReady) nxt = FETCH;
            end
            EXECR: begin
                src_a = 2'b10;
                alu   = r_alu;
                nxt   = ALUWB;
            end
            EXECI: begin
                src_a = 2'b10;
                src_b = 2'b01;
                alu   = f3_alu;
                nxt   = ALUWB;
            end
            LUI: begin
                src_a   = 2'b11;
                src_b   = 2'b01;
                imm_src = IMM_U;
                nxt     = ALUWB;
            end
            ALUWB: begin
                reg_write = 1'b1;
                nxt       = FETCH;
            end
            BRANCH: begin
                src_a    = 2'b10;
                alu      = ALU_SUB;
                pc_write = bus.Funct3[0] ? !bus.Zero : bus.Zero;
                nxt      = FETCH;
            end
            JAL: begin
                // OldPC + 4 goes to rd via ALUWB; PC takes the target.
                src_a    = 2'b01;
                src_b    = 2'b10;
                pc_write = 1'b1;
                nxt      = ALUWB;
            end
            TRAP: begin
                illegal = 1'b1;
                nxt     = TRAP;
            end
            default: nxt = TRAP;
        endcase
    end

    always_comb begin
        ula_ext      = '0;
        ula_ext[2:0] = alu;
    end

    // Reset holds every output low so an abandoned access never strobes.
    assign bus.PCWrite    = RSTn & pc_write;
    assign bus.AdrSrc     = RSTn & adr_src;
    assign bus.MemWrite   = RSTn & mem_write;
    assign bus.IRWrite    = RSTn & ir_write;
    assign bus.RegWrite   = RSTn & reg_write;
    assign bus.Illegal    = RSTn & illegal;
    assign bus.ResultSrc  = RSTn ? result_src : 2'b00;
    assign bus.ULASrcA    = RSTn ? src_a : 2'b00;
    assign bus.ULASrcB    = RSTn ? src_b : 2'b00;
    assign bus.ULAControl = RSTn ? ula_ext : '0;
    assign bus.ImmSrc     = RSTn ? imm_src : 3'b000;
    assign bus.State      = RSTn ? state : 4'd0;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb_multicycle_control_unit: scoreboard bench; an instruction-level model
// plans per-cycle stimulus and expected controls, a monitor compares them.
module tb_multicycle_control_unit;

    localparam int ULA_W = 3;
    localparam int K_LD  = 0;
    localparam int K_ST  = 1;
    localparam int K_R   = 2;
    localparam int K_I   = 3;
    localparam int K_LUI = 4;
    localparam int K_BR  = 5;
    localparam int K_JAL = 6;
    localparam int K_BAD = 7;

    typedef struct {
        bit       rstn;
        bit       mr;
        bit       zero;
        bit       chk2;
        bit [6:0] op;
        bit [2:0] f3;
        bit [6:0] f7;
        int       st, pcw, adr, mw, irw, rw, ill;
        int       rs, sa, sb, ula, imm;
        int       st2, ill2;
    } cyc_t;

    logic CLK = 1'b0;
    logic RSTn = 1'b0;
    always #5 CLK = ~CLK;

    multicycle_control_unit_if #(.ULA_W(ULA_W)) bus ();
    multicycle_control_unit_if #(.ULA_W(ULA_W)) bus2 ();

    assign bus2.OP       = bus.OP;
    assign bus2.Funct3   = bus.Funct3;
    assign bus2.Funct7   = bus.Funct7;
    assign bus2.Zero     = bus.Zero;
    assign bus2.MemReady = bus.MemReady;

    multicycle_control_unit #(
        .ULA_W(ULA_W), .ENABLE_BNE(1'b1), .ENABLE_JAL(1'b1)
    ) dut (
        .CLK(CLK), .RSTn(RSTn), .bus(bus)
    );

    multicycle_control_unit #(
        .ULA_W(ULA_W), .ENABLE_BNE(1'b1), .ENABLE_JAL(1'b0)
    ) dut2 (
        .CLK(CLK), .RSTn(RSTn), .bus(bus2)
    );

    int   total = 0;
    int   bad   = 0;
    int   cyc_n = 0;
    cyc_t plan[$];
    cyc_t exp_q[$];
    bit [6:0] c_op;
    bit [2:0] c_f3;
    bit [6:0] c_f7;
    bit   trap2 = 1'b0;
    // ALU code selected by funct3 for R/I-type (funct3 011 never reaches it).
    int   alu_tab[8] = '{0, 6, 5, 0, 4, 7, 3, 2};

    // Instruction class from the legal-encoding list.
    function automatic int kind(bit [6:0] op, bit [2:0] f3, bit [6:0] f7);
        case (op)
            7'h03: return (f3 == 3'd2) ? K_LD : K_BAD;
            7'h23: return (f3 == 3'd2) ? K_ST : K_BAD;
            7'h33: begin
                if (f7 == 7'h00 && f3 != 3'd3) return K_R;
                if (f7 == 7'h20 && f3 == 3'd0) return K_R;
                return K_BAD;
            end
            7'h13: begin
                if (f3 == 3'd3) return K_BAD;
                if ((f3 == 3'd1 || f3 == 3'd5) && f7 != 7'h00) return K_BAD;
                return K_I;
            end
            7'h37:   return K_LUI;
            7'h63:   return (f3 <= 3'd1) ? K_BR : K_BAD;
            7'h6F:   return K_JAL;
            default: return K_BAD;
        endcase
    endfunction

    function automatic cyc_t base(int st);
        cyc_t c;
        c = '{default: 0};
        c.rstn = 1'b1;
        c.op   = c_op;
        c.f3   = c_f3;
        c.f7   = c_f7;
        c.mr   = 1'($urandom_range(0, 1));
        c.zero = 1'($urandom_range(0, 1));
        c.st   = st;
        if (trap2) begin
            c.chk2 = 1'b1;
            c.st2  = 12;
            c.ill2 = 1;
        end
        return c;
    endfunction

    function automatic cyc_t reset_rec();
        cyc_t c;
        c = base(0);
        c.rstn = 1'b0;
        c.chk2 = 1'b1;
        c.st2  = 0;
        c.ill2 = 0;
        return c;
    endfunction

    task automatic set_instr(input bit [6:0] op, input bit [2:0] f3,
                             input bit [6:0] f7);
        c_op = op;
        c_f3 = f3;
        c_f7 = f7;
    endtask

    task automatic push_aluwb();
        cyc_t c;
        c = base(7);
        c.rw = 1;
        plan.push_back(c);
    endtask

    task automatic plan_instr(input int wf, input int wm, input int zf,
                              input bit abort, input bit mark2);
        cyc_t c;
        int   k;
        k = kind(c_op, c_f3, c_f7);
        for (int i = 0; i <= wf; i++) begin
            c = base(0);
            c.mr  = (i == wf);
            c.pcw = int'(c.mr);
            c.irw = int'(c.mr);
            c.sb  = 2;
            c.rs  = 2;
            plan.push_back(c);
        end
        c = base(1);
        c.sa  = 1;
        c.sb  = 1;
        c.imm = (c_op == 7'h6F) ? 4 : 2;
        plan.push_back(c);
        if (mark2) trap2 = 1'b1;
        case (k)
            K_BAD: begin
                repeat (5) begin
                    c = base(12);
                    c.ill = 1;
                    plan.push_back(c);
                end
                plan.push_back(reset_rec());
            end
            K_LD, K_ST: begin
                c = base(2);
                c.sa  = 2;
                c.sb  = 1;
                c.imm = (k == K_ST) ? 1 : 0;
                plan.push_back(c);
                if (abort) begin
                    c = base(5);
                    c.adr = 1;
                    c.mw  = 1;
                    c.mr  = 1'b0;
                    plan.push_back(c);
                    c = reset_rec();
                    c.mr = 1'b0;
                    plan.push_back(c);
                    return;
                end
                for (int i = 0; i <= wm; i++) begin
                    c = base((k == K_ST) ? 5 : 3);
                    c.adr = 1;
                    c.mw  = (k == K_ST) ? 1 : 0;
                    c.mr  = (i == wm);
                    plan.push_back(c);
                end
                if (k == K_LD) begin
                    c = base(4);
                    c.rs = 1;
                    c.rw = 1;
                    plan.push_back(c);
                end
            end
            K_R: begin
                c = base(6);
                c.sa  = 2;
                c.ula = (c_f7 == 7'h20) ? 1 : alu_tab[c_f3];
                plan.push_back(c);
                push_aluwb();
            end
            K_I: begin
                c = base(8);
                c.sa  = 2;
                c.sb  = 1;
                c.ula = alu_tab[c_f3];
                plan.push_back(c);
                push_aluwb();
            end
            K_LUI: begin
                c = base(11);
                c.sa  = 3;
                c.sb  = 1;
                c.imm = 3;
                plan.push_back(c);
                push_aluwb();
            end
            K_BR: begin
                c = base(10);
                if (zf >= 0) c.zero = 1'(zf);
                c.sa  = 2;
                c.ula = 1;
                c.pcw = (c_f3 == 3'd0) ? int'(c.zero) : int'(!c.zero);
                plan.push_back(c);
            end
            default: begin
                c = base(9);
                c.sa  = 1;
                c.sb  = 2;
                c.pcw = 1;
                plan.push_back(c);
                push_aluwb();
            end
        endcase
    endtask

    task automatic run_plan();
        cyc_t c;
        while (plan.size() > 0) begin
            c = plan.pop_front();
            bus.OP       = c.op;
            bus.Funct3   = c.f3;
            bus.Funct7   = c.f7;
            bus.Zero     = c.zero;
            bus.MemReady = c.mr;
            RSTn         = c.rstn;
            exp_q.push_back(c);
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic rand_instr();
        bit [6:0] ops[7];
        int       r;
        ops = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h37, 7'h63, 7'h6F};
        r = int'($urandom_range(0, 15));
        c_op = (r < 14) ? ops[r % 7] : 7'($urandom);
        c_f3 = 3'($urandom);
        if ((c_op == 7'h03 || c_op == 7'h23) && $urandom_range(0, 3) != 0)
            c_f3 = 3'd2;
        if (c_op == 7'h63 && $urandom_range(0, 3) != 0)
            c_f3 = {2'b00, 1'($urandom)};
        case ($urandom_range(0, 3))
            0:       c_f7 = 7'($urandom);
            1:       c_f7 = 7'h20;
            default: c_f7 = 7'h00;
        endcase
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cycle %0d, t=%0t)",
                     name, act, exp, cyc_n, $time);
        end
    endtask

    always @(negedge CLK) begin
        cyc_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            cyc_n++;
            chk("State",      32'(bus.State),      e.st);
            chk("PCWrite",    32'(bus.PCWrite),    e.pcw);
            chk("AdrSrc",     32'(bus.AdrSrc),     e.adr);
            chk("MemWrite",   32'(bus.MemWrite),   e.mw);
            chk("IRWrite",    32'(bus.IRWrite),    e.irw);
            chk("RegWrite",   32'(bus.RegWrite),   e.rw);
            chk("Illegal",    32'(bus.Illegal),    e.ill);
            chk("ResultSrc",  32'(bus.ResultSrc),  e.rs);
            chk("ULASrcA",    32'(bus.ULASrcA),    e.sa);
            chk("ULASrcB",    32'(bus.ULASrcB),    e.sb);
            chk("ULAControl", 32'(bus.ULAControl), e.ula);
            chk("ImmSrc",     32'(bus.ImmSrc),     e.imm);
            if (e.chk2) begin
                chk("State_nojal",   32'(bus2.State),   e.st2);
                chk("Illegal_nojal", 32'(bus2.Illegal), e.ill2);
            end
        end
    end

    initial begin
        bus.OP       = 7'h00;
        bus.Funct3   = 3'd0;
        bus.Funct7   = 7'h00;
        bus.Zero     = 1'b0;
        bus.MemReady = 1'b0;
        RSTn         = 1'b0;
        set_instr(7'h13, 3'd0, 7'h00);
        @(posedge CLK);
        #1;
        plan.push_back(reset_rec());
        plan.push_back(reset_rec());
        run_plan();

        set_instr(7'h33, 3'd0, 7'h00);
        plan_instr(0, 0, -1, 1'b0, 1'b0);
        run_plan();

        set_instr(7'h03, 3'd2, 7'h00);
        plan_instr(2, 3, -1, 1'b0, 1'b0);
        run_plan();

        set_instr(7'h63, 3'd0, 7'h00);
        plan_instr(0, 0, 1, 1'b0, 1'b0);
        set_instr(7'h63, 3'd1, 7'h00);
        plan_instr(0, 0, 1, 1'b0, 1'b0);
        run_plan();

        set_instr(7'h6F, 3'd5, 7'h11);
        plan_instr(0, 0, -1, 1'b0, 1'b1);
        set_instr(7'h33, 3'd4, 7'h00);
        plan_instr(0, 0, -1, 1'b0, 1'b0);
        trap2 = 1'b0;
        plan.push_back(reset_rec());
        run_plan();

        set_instr(7'h33, 3'd7, 7'h20);
        plan_instr(0, 0, -1, 1'b0, 1'b0);
        run_plan();

        set_instr(7'h23, 3'd2, 7'h00);
        plan_instr(0, 0, -1, 1'b1, 1'b0);
        set_instr(7'h13, 3'd6, 7'h55);
        plan_instr(1, 0, -1, 1'b0, 1'b0);
        run_plan();

        for (int n = 0; n < 300; n++) begin
            rand_instr();
            plan_instr(int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                       -1, 1'b0, 1'b0);
            run_plan();
        end

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge CLK);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
Moore-style control FSM for the multi-cycle RV32 datapath. It replaces the single-cycle combinational decoder and sequences each instruction through fetch, decode, execute, memory and writeback states. It sits between the instruction register (which supplies OP, Funct3 and Funct7) and the datapath muxes, register file, PC and unified memory. Memory access uses a MemReady wait handshake. BNE and JAL are optional, and an illegal-instruction trap is provided.

Parameters:
ULA_W, 3, width of ULAControl (must be ≥3); codes are zero-extended.
ENABLE_BNE, 1, decode BNE (funct3 001); when 0, BNE traps.
ENABLE_JAL, 1, decode JAL (OP 1101111); when 0, JAL traps.

Ports:
CLK  in  1  clock; all state changes on the rising edge.
RSTn  in  1  synchronous active-low reset.
OP  in  7  IR[6:0].
Funct3  in  3  IR[14:12].
Funct7  in  7  IR[31:25].
Zero  in  1  ULA zero flag.
MemReady  in  1  memory completes the access this cycle.
PCWrite  out  1  PC load enable.
AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut.
MemWrite  out  1  memory write strobe.
IRWrite  out  1  IR and OldPC load enable.
ResultSrc  out  2  result select: 00 = ALUOut, 01 = memory data, 10 = ULA result.
ULASrcA  out  2  A operand select: 00 = PC, 01 = OldPC, 10 = rs1, 11 = zero.
ULASrcB  out  2  B operand select: 00 = rs2, 01 = immediate, 10 = constant 4.
ULAControl  out  ULA_W  ULA operation: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLT, 110 SLL, 111 SRL.
ImmSrc  out  3  immediate format: 000 I, 001 S, 010 B, 011 U, 100 J.
RegWrite  out  1  register file write enable.
Illegal  out  1  sticky trap flag.
State  out  4  current state, for debug.

Behaviour:
- State register only. On a CLK edge with RSTn=0, State becomes FETCH (0). While RSTn=0, all outputs are forced to 0: PCWrite, IRWrite, MemWrite, RegWrite, Illegal. Reset mid-instruction abandons the instruction with no pending write.
- Unlisted outputs in any state are 0 / 000.
- State encodings: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, ALUWB 7, EXECI 8, JAL 9, BRANCH 10, LUI 11, TRAP 12. Encodings 13–15 go to TRAP on the next edge.
- FETCH:
  - AdrSrc=0, ULASrcA=00, ULASrcB=10, ADD, ResultSrc=10.
  - IRWrite=PCWrite=MemReady.
  - Hold in FETCH while MemReady=0; go to DECODE when MemReady=1.
- DECODE:
  - ULASrcA=01, ULASrcB=01, ADD (computes branch/jump target into ALUOut).
  - ImmSrc=100 if OP is JAL, else 010.
  - Next state by OP: 0000011 or 0100011 → MEMADR; 0110011 → EXECR; 0010011 → EXECI; 0110111 → LUI; 1100011 → BRANCH; 1101111 → JAL.
  - Go to TRAP instead if any of these hold:
    - OP is not listed, or is disabled by a parameter.
    - Load/store with Funct3≠010.
    - R-type with {Funct7,Funct3} not among: ADD 0000000/000, SUB 0100000/000, SLL 001, SLT 010, XOR 100, SRL 101, OR 110, AND 111 (all except SUB with Funct7=0).
    - I-type Funct3=011.
    - SLLI/SRLI with Funct7≠0.
    - Branch with Funct3 not 000 (or 001 when ENABLE_BNE).
- MEMADR: ULASrcA=10, ULASrcB=01, ADD, ImmSrc=000 for load / 001 for store. Next: load → MEMREAD, store → MEMWRITE.
- MEMREAD: AdrSrc=1. Hold until MemReady=1, then go to MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1. Next: FETCH.
- MEMWRITE: AdrSrc=1, MemWrite=1, held high until MemReady=1. Next: FETCH.
- EXECR: ULASrcA=10, ULASrcB=00, ULAControl from funct. Next: ALUWB.
- EXECI: ULASrcA=10, ULASrcB=01, ImmSrc=000, op from Funct3 (same mapping as R-type, no SUB). Next: ALUWB.
- LUI: ULASrcA=11, ULASrcB=01, ImmSrc=011, ADD. Next: ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1. Next: FETCH.
- BRANCH:
  - ULASrcA=10, ULASrcB=00, SUB, ResultSrc=00.
  - PCWrite=Zero for BEQ, or !Zero for BNE.
  - Next: FETCH.
- JAL: ULASrcA=01, ULASrcB=10, ADD, ResultSrc=00, PCWrite=1. Next: ALUWB, which writes OldPC+4 to rd.
- TRAP: Illegal=1 and all enables 0. The FSM stays in TRAP until reset.
- Cycle counts (with MemReady=1 on every access): R/I-type/LUI 4, LW 5, SW 4, branch 3, JAL 4. Each MemReady=0 cycle adds one cycle.
- OP and Funct are sampled combinationally. They are stable because IR loads only in FETCH.

Test Plan:
- ADD (OP 0110011, Funct3 000, Funct7 0), MemReady=1 → states 0,1,6,7,0; ULAControl=000 in EXECR; RegWrite=1 only in ALUWB.
- LW with MemReady low for 2 cycles in FETCH and 3 cycles in MEMREAD → 10 cycles total; IRWrite pulses once; ResultSrc=01 with RegWrite=1 in MEMWB.
- BEQ with Zero=1, then BNE with Zero=1 → PCWrite=1 in BRANCH for BEQ, 0 for BNE; ULAControl=001; 3 cycles each.
- JAL → ImmSrc=100 in DECODE; PCWrite=1 in JAL; RegWrite=1 in ALUWB. Repeat with ENABLE_JAL=0 → State=12, Illegal=1, held for 5 or more cycles.
- R-type with Funct7=0100000, Funct3=111 → TRAP; then RSTn=0 for 1 edge → State=0, Illegal=0.
- SW with RSTn dropped during MEMWRITE while MemReady=0 → MemWrite falls in the same cycle; State=0 after the edge; the next FETCH proceeds normally.
